cmos_pattern_gen: RTL and testbench
===================================

# cmos_pattern_gen

Synthetic DVP camera source that emits OV5640-style frame timing (`cmos_vsync`, `cmos_href`, 16-bit RGB565 `cmos_data`) from `sys_clk`. It stands in for a physical sensor on either input of the dual-camera merge path (`u_cmos_add`), so that merge, FIFO and analyzer captures can be exercised with a deterministic, frame-stamped pattern. Frames start and stop only on frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, default 640: pixels per active line (multiple of 8)
- `H_BLANK`, default 160: blank cycles per line; `H_TOTAL = H_ACTIVE + H_BLANK`
- `VSYNC_LINES`, default 4: lines with `cmos_vsync` high
- `V_BACK`, default 16: lines after vsync before the first active line
- `V_ACTIVE`, default 480: active lines per frame
- `V_FRONT`, default 10: lines after the last active line; `V_TOTAL` = sum of the four vertical parameters

Ports:
- `sys_clk`, in, 1: pixel clock; the only clock
- `sys_rst`, in, 1: asynchronous, active-high reset
- `enable`, in, 1: level; request frame generation
- `pattern_sel`, in, 2: 0 colour bars, 1 ramp, 2 moving diagonal, 3 checker
- `cmos_vsync`, out, 1: frame sync, active high
- `cmos_href`, out, 1: line valid, active high
- `cmos_data`, out, 16: RGB565 pixel; 0 whenever `cmos_href` = 0
- `frame_cnt`, out, 8: count of completed frames, wraps 255→0
- `frame_done`, out, 1: one-cycle pulse on the last cycle of each frame
- `busy`, out, 1: high while in RUN

## Operation
- Two-state FSM:
  - IDLE → RUN when `enable` = 1. `h_cnt`, `v_cnt` and `pat_q` load on the same edge: counters to 0, `pat_q` ← `pattern_sel`.
  - RUN → IDLE at the frame end (`h_cnt` = `H_TOTAL`-1, `v_cnt` = `V_TOTAL`-1) when `enable` = 0. Otherwise RUN continues with the next frame.
- Frame behaviour:
  - Dropping `enable` mid-frame does not truncate the frame. The current frame always completes.
  - `pat_q` re-samples `pattern_sel` at every frame start. Changes to `pattern_sel` mid-frame are ignored.
- Counters in RUN:
  - `h_cnt` counts 0..`H_TOTAL`-1 and wraps.
  - `v_cnt` increments when `h_cnt` wraps, and wraps at `V_TOTAL`-1.
- Sync and valid decode (from counter values):
  - vsync_n = `v_cnt` < `VSYNC_LINES`
  - href_n = `v_cnt` ∈ [`VSYNC_LINES`+`V_BACK`, +`V_ACTIVE`) and `h_cnt` < `H_ACTIVE`
- Pixel data:
  - Let `ay` = `v_cnt` − (`VSYNC_LINES`+`V_BACK`), the active row index. All arithmetic is 16-bit and wraps.
  - Pattern 0, colour bars: bar = `h_cnt` / (`H_ACTIVE`/8). Bars 0..7 = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Pattern 1, ramp: `h_cnt[15:0]`.
  - Pattern 2, moving diagonal: `h_cnt` + `ay` + {8'd0, `frame_cnt`}.
  - Pattern 3, checker: (`h_cnt[3]` ^ `ay[3]`) ? FFFF : 0000.
- `frame_cnt` increments at each frame end.
- `frame_done` asserts for that same frame-end cycle, registered.
- IDLE outputs: `cmos_vsync`, `cmos_href`, `cmos_data` and `busy` all 0. `frame_cnt` holds its value.
- Reset values: FSM = IDLE, counters = 0, `pat_q` = 0, all outputs = 0.
  - Reset mid-frame aborts the frame immediately. Outputs are 0 on the next observable edge.

## Timing
- Latency: `cmos_vsync`, `cmos_href` and `cmos_data` are registered from the decode of `h_cnt`/`v_cnt`. All three lag the counters by exactly 1 cycle and are mutually aligned.
- First frame after IDLE→RUN:
  - `cmos_vsync` rises 1 cycle after the first RUN cycle.
  - The first `cmos_href` rise is (`VSYNC_LINES`+`V_BACK`)·`H_TOTAL`+1 cycles after RUN entry.
- Steady-state waveforms:
  - Each `cmos_href` pulse is exactly `H_ACTIVE` cycles; line period is `H_TOTAL`.
  - `cmos_vsync` stays high for `VSYNC_LINES`·`H_TOTAL` cycles.
  - Frame period is `H_TOTAL`·`V_TOTAL` cycles with no gap between back-to-back frames.
- Simultaneous events at frame end:
  - `enable` = 0 at frame end: `frame_done` pulses, `frame_cnt` increments, FSM enters IDLE.
  - `enable` = 1 at frame end: the next frame starts on the following cycle with the newly sampled pattern.
- `frame_done` and the `frame_cnt` update appear on the same output edge.

## Structure
- Shared package `cmos_pkg`:
  - RGB565 bar-colour constants
  - pattern-select enum (BAR, RAMP, DIAG, CHECK)
  - FSM state enum (IDLE, RUN)
- One natural sub-module, `cmos_timing_cnt`: the h/v counters with the wrap and frame-end strobe.
  - Its counters are also reusable for later merge-path checkers.
- Pattern mux and output registers live in the top module.

## Test plan
Bench parameters: `H_ACTIVE`=16, `H_BLANK`=4, `VSYNC_LINES`=1, `V_BACK`=1, `V_ACTIVE`=3, `V_FRONT`=1 (`H_TOTAL`=20, `V_TOTAL`=6, frame = 120 cycles).
- Reset state: hold `sys_rst` 5 cycles with `enable`=1 → all outputs 0. After release, `busy`=1 on the next edge, `cmos_vsync`=1 one cycle later for 20 cycles.
- Line timing: pattern 1 → 3 href pulses of 16 cycles per frame. Data ramps 0..15 on each pulse. `cmos_data`=0 between pulses.
- Colour bars: pattern 0 → each line reads FFFF,FFFF,FFE0,FFE0,…,0000,0000 (2 pixels per bar).
- Frame stamping: pattern 2, run 3 frames → `frame_done` pulses at cycles 120, 240, 360 after RUN entry. `frame_cnt` reads 1/2/3. First pixel of the second frame = 0001.
- Stop and pattern change: drop `enable` at frame cycle 50 → the frame completes, then IDLE with outputs 0. Change `pattern_sel` mid-frame → takes effect only at the next frame start.
- Mid-frame reset: assert `sys_rst` during an href pulse → `cmos_href`/`cmos_data` go 0 immediately and `frame_cnt` = 0.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and constants for the synthetic DVP camera source.
// Bar colours follow the classic white..black SMPTE-style order in RGB565.
package cmos_pkg;

    typedef enum logic [1:0] {
        BAR   = 2'd0,
        RAMP  = 2'd1,
        DIAG  = 2'd2,
        CHECK = 2'd3
    } pattern_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [15:0] bar);
        logic [15:0] c;
        case (bar)
            16'd0:   c = RGB_WHITE;
            16'd1:   c = RGB_YELLOW;
            16'd2:   c = RGB_CYAN;
            16'd3:   c = RGB_GREEN;
            16'd4:   c = RGB_MAGENTA;
            16'd5:   c = RGB_RED;
            16'd6:   c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmos_timing_cnt.sv
// Horizontal/vertical raster counters with frame-end strobe.
// clear forces a fresh frame origin; run advances the raster by one pixel.
module cmos_timing_cnt #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 510
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        clear,
    input  logic        run,
    output logic [15:0] h_cnt,
    output logic [15:0] v_cnt,
    output logic        frame_end
);

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    logic line_end;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt <= 16'd0;
            v_cnt <= 16'd0;
        end else if (clear) begin
            h_cnt <= 16'd0;
            v_cnt <= 16'd0;
        end else if (run) begin
            if (line_end) begin
                h_cnt <= 16'd0;
                v_cnt <= frame_end ? 16'd0 : v_cnt + 16'd1;
            end else begin
                h_cnt <= h_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/cmos_pattern_gen.sv
// OV5640-style DVP frame source with selectable test patterns.
// Sync, valid and pixel outputs are registered one cycle behind the raster counters.
module cmos_pattern_gen
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic [7:0]  frame_cnt,
    output logic        frame_done,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_SYNC = 16'(VSYNC_LINES);
    localparam logic [15:0] V_ACT0 = 16'(VSYNC_LINES + V_BACK);
    localparam logic [15:0] V_ACT1 = 16'(VSYNC_LINES + V_BACK + V_ACTIVE);
    localparam logic [15:0] BAR_W  = 16'(H_ACTIVE / 8);

    state_e      state;
    pattern_e    pat_q;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        frame_end;
    logic        start;
    logic        vsync_n;
    logic        href_n;
    logic [15:0] ay;
    logic [15:0] pix;

    assign start = (state == IDLE) && enable;

    cmos_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear     (start),
        .run       (state == RUN),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .frame_end (frame_end)
    );

    assign vsync_n = (v_cnt < V_SYNC);
    assign href_n  = (v_cnt >= V_ACT0) && (v_cnt < V_ACT1) && (h_cnt < H_ACT);
    assign ay      = v_cnt - V_ACT0;

    // Diagonal mixes in frame_cnt so each frame is visibly stamped.
    always_comb begin
        pix = RGB_BLACK;
        case (pat_q)
            BAR:   pix = bar_color(h_cnt / BAR_W);
            RAMP:  pix = h_cnt;
            DIAG:  pix = h_cnt + ay + {8'd0, frame_cnt};
            CHECK: pix = (h_cnt[3] ^ ay[3]) ? RGB_WHITE : RGB_BLACK;
            default: pix = RGB_BLACK;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            pat_q      <= BAR;
            busy       <= 1'b0;
            frame_cnt  <= 8'd0;
            frame_done <= 1'b0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= 16'd0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        pat_q <= pattern_e'(pattern_sel);
                    end
                end
                RUN: begin
                    cmos_vsync <= vsync_n;
                    cmos_href  <= href_n;
                    cmos_data  <= href_n ? pix : 16'd0;
                    if (frame_end) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        // Stop requests only take effect on a frame boundary.
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            pat_q <= pattern_e'(pattern_sel);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// Directed bench for cmos_pattern_gen on a 20x6 raster (120-cycle frames).
// Cycle k counts edges since RUN entry; outputs are sampled 1ns after each edge.
module tb_cmos_pattern_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [15:0] cmos_data;
    logic [7:0]  frame_cnt;
    logic        frame_done;
    logic        busy;

    cmos_pattern_gen #(
        .H_ACTIVE    (16),
        .H_BLANK     (4),
        .VSYNC_LINES (1),
        .V_BACK      (1),
        .V_ACTIVE    (3),
        .V_FRONT     (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .frame_cnt   (frame_cnt),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          cyc;
        logic        en;
        logic [1:0]  sel;
        logic        busy;
        logic        vs;
        logic        hr;
        logic [15:0] data;
        logic        done;
        logic [7:0]  fcnt;
    } vec_t;

    vec_t tbl[$];
    int   k;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge sys_clk);
        #1;
        k++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic add(input int cyc, input logic en, input logic [1:0] sel,
                       input logic b, input logic vs, input logic hr,
                       input logic [15:0] d, input logic dn, input logic [7:0] fc);
        vec_t v;
        v.cyc = cyc; v.en = en; v.sel = sel; v.busy = b; v.vs = vs;
        v.hr = hr; v.data = d; v.done = dn; v.fcnt = fc;
        tbl.push_back(v);
    endtask

    initial begin
        int done_k[3];
        int done_f[3];
        int nd;
        int rise_k[3];
        int nr;
        int high_cnt;
        int viol;
        logic prev_href;

        // frame 0 ramp; sel->bars mid-frame (ignored until frame 1)
        add(  0, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
        add(  1, 1, 1, 1, 1, 0, 16'h0000, 0, 0);
        add( 20, 1, 1, 1, 1, 0, 16'h0000, 0, 0);
        add( 21, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
        add( 40, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
        add( 41, 1, 1, 1, 0, 1, 16'h0000, 0, 0);
        add( 46, 1, 1, 1, 0, 1, 16'h0005, 0, 0);
        add( 56, 1, 1, 1, 0, 1, 16'h000F, 0, 0);
        add( 57, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
        add( 60, 1, 0, 1, 0, 0, 16'h0000, 0, 0);
        add( 61, 1, 0, 1, 0, 1, 16'h0000, 0, 0);
        add( 63, 1, 0, 1, 0, 1, 16'h0002, 0, 0);
        add( 96, 1, 0, 1, 0, 1, 16'h000F, 0, 0);
        add(101, 1, 0, 1, 0, 0, 16'h0000, 0, 0);
        add(119, 1, 0, 1, 0, 0, 16'h0000, 0, 0);
        add(120, 1, 0, 1, 0, 0, 16'h0000, 1, 1);
        add(121, 1, 0, 1, 1, 0, 16'h0000, 0, 1);
        // frame 1 colour bars
        add(161, 1, 0, 1, 0, 1, 16'hFFFF, 0, 1);
        add(162, 1, 0, 1, 0, 1, 16'hFFFF, 0, 1);
        add(163, 1, 0, 1, 0, 1, 16'hFFE0, 0, 1);
        add(166, 1, 0, 1, 0, 1, 16'h07FF, 0, 1);
        add(167, 1, 0, 1, 0, 1, 16'h07E0, 0, 1);
        add(169, 1, 0, 1, 0, 1, 16'hF81F, 0, 1);
        add(172, 1, 0, 1, 0, 1, 16'hF800, 0, 1);
        add(173, 1, 0, 1, 0, 1, 16'h001F, 0, 1);
        add(176, 1, 0, 1, 0, 1, 16'h0000, 0, 1);
        add(177, 1, 0, 1, 0, 0, 16'h0000, 0, 1);
        add(200, 1, 2, 1, 0, 0, 16'h0000, 0, 1);
        add(240, 1, 2, 1, 0, 0, 16'h0000, 1, 2);
        // frame 2 diagonal (frame_cnt=2); sel->checker mid-frame
        add(241, 1, 2, 1, 1, 0, 16'h0000, 0, 2);
        add(281, 1, 2, 1, 0, 1, 16'h0002, 0, 2);
        add(285, 1, 2, 1, 0, 1, 16'h0006, 0, 2);
        add(290, 1, 2, 1, 0, 1, 16'h000B, 0, 2);
        add(300, 1, 3, 1, 0, 0, 16'h0000, 0, 2);
        add(301, 1, 3, 1, 0, 1, 16'h0003, 0, 2);
        add(316, 1, 3, 1, 0, 1, 16'h0012, 0, 2);
        add(321, 1, 3, 1, 0, 1, 16'h0004, 0, 2);
        add(360, 1, 3, 1, 0, 0, 16'h0000, 1, 3);
        add(361, 1, 3, 1, 1, 0, 16'h0000, 0, 3);
        // frame 3 checker; enable dropped at frame cycle 50
        add(401, 1, 3, 1, 0, 1, 16'h0000, 0, 3);
        add(409, 1, 3, 1, 0, 1, 16'hFFFF, 0, 3);
        add(410, 0, 3, 1, 0, 1, 16'hFFFF, 0, 3);
        add(416, 0, 3, 1, 0, 1, 16'hFFFF, 0, 3);
        add(417, 0, 3, 1, 0, 0, 16'h0000, 0, 3);
        add(421, 0, 3, 1, 0, 1, 16'h0000, 0, 3);
        add(429, 0, 3, 1, 0, 1, 16'hFFFF, 0, 3);
        add(480, 0, 3, 0, 0, 0, 16'h0000, 1, 4);
        add(481, 0, 3, 0, 0, 0, 16'h0000, 0, 4);
        add(500, 0, 3, 0, 0, 0, 16'h0000, 0, 4);

        sys_rst = 1'b1;
        enable = 1'b1;
        pattern_sel = 2'd1;
        k = 0;
        repeat (5) step();
        chk("rst_busy",  busy, 0);
        chk("rst_vsync", cmos_vsync, 0);
        chk("rst_href",  cmos_href, 0);
        chk("rst_data",  cmos_data, 0);
        chk("rst_fcnt",  frame_cnt, 0);
        chk("rst_done",  frame_done, 0);

        sys_rst = 1'b0;
        k = -1;
        foreach (tbl[i]) begin
            while (k < tbl[i].cyc) step();
            chk("tbl_busy",  busy, tbl[i].busy);
            chk("tbl_vsync", cmos_vsync, tbl[i].vs);
            chk("tbl_href",  cmos_href, tbl[i].hr);
            chk("tbl_data",  cmos_data, tbl[i].data);
            chk("tbl_done",  frame_done, tbl[i].done);
            chk("tbl_fcnt",  frame_cnt, tbl[i].fcnt);
            enable = tbl[i].en;
            pattern_sel = tbl[i].sel;
        end

        // mid-frame reset during an href pulse
        enable = 1'b1;
        pattern_sel = 2'd1;
        for (int i = 0; i < 100 && !cmos_href; i++) step();
        chk("mr_href_up", cmos_href, 1);
        repeat (3) step();
        chk("mr_href_hold", cmos_href, 1);
        chk("mr_fcnt_pre", frame_cnt, 4);
        #2 sys_rst = 1'b1;
        #1;
        chk("mr_href",  cmos_href, 0);
        chk("mr_data",  cmos_data, 0);
        chk("mr_fcnt",  frame_cnt, 0);
        chk("mr_busy",  busy, 0);
        chk("mr_vsync", cmos_vsync, 0);
        enable = 1'b0;
        repeat (2) step();
        sys_rst = 1'b0;
        step();
        chk("mr_idle_busy", busy, 0);

        // three back-to-back diagonal frames
        enable = 1'b1;
        pattern_sel = 2'd2;
        nd = 0; nr = 0; high_cnt = 0; viol = 0; prev_href = 1'b0;
        for (int i = 0; i < 3; i++) begin
            done_k[i] = -1; done_f[i] = -1; rise_k[i] = -1;
        end
        k = -1;
        while (k < 400) begin
            step();
            if (frame_done) begin
                if (nd < 3) begin
                    done_k[nd] = k;
                    done_f[nd] = int'(frame_cnt);
                end
                nd++;
            end
            if (k >= 1 && k <= 120) begin
                if (cmos_href) high_cnt++;
                if (cmos_href && !prev_href) begin
                    if (nr < 3) rise_k[nr] = k;
                    nr++;
                end
            end
            if (!cmos_href && cmos_data != 16'd0) viol++;
            if (k == 161) begin
                chk("fs_f1_href", cmos_href, 1);
                chk("fs_f1_pix0", cmos_data, 16'h0001);
            end
            prev_href = cmos_href;
            if (k == 330) enable = 1'b0;
        end
        chk("fs_done_count", nd, 3);
        for (int i = 0; i < 3; i++) begin
            chk("fs_done_cycle", done_k[i], 120 * (i + 1));
            chk("fs_done_fcnt", done_f[i], i + 1);
            chk("lt_href_rise", rise_k[i], 41 + 20 * i);
        end
        chk("lt_href_pulses", nr, 3);
        chk("lt_href_cycles", high_cnt, 48);
        chk("lt_data_blank", viol, 0);
        chk("fs_end_busy", busy, 0);
        chk("fs_end_fcnt", frame_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
